// File: rtl/st_decoder_if.sv
// Shared types and stream interfaces for the packet decoder.
// The package comes first so both interfaces and the decoder can use its types.
package st_decoder_pkg;

  typedef enum logic [7:0] {
    MSG_NONE = 8'h00,
    MSG_UDP1 = 8'h01
  } msg_type_supported_t;

  typedef enum logic [1:0] {
    ERR_TYPE  = 2'd0,
    ERR_SHORT = 2'd1,
    ERR_NOSOP = 2'd2,
    ERR_LONG  = 2'd3
  } err_code_e;

  typedef struct packed {
    msg_type_supported_t msg_type;
    logic [31:0]         seq_num;
    logic                seq_num_avail;
    logic [15:0]         src_port;
    logic                src_port_avail;
    logic [15:0]         dst_port;
    logic                dst_port_avail;
    logic [15:0]         length;
    logic                length_avail;
  } fields_t;

endpackage

interface st_pkt_intf #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              sop;
  logic              eop;

  modport master (output data, valid, sop, eop, input ready);
  modport slave  (input data, valid, sop, eop, output ready);
endinterface

interface st_intf;
  st_decoder_pkg::msg_type_supported_t data;
  logic                                valid;
  logic                                ready;

  modport master (output data, valid, input ready);
  modport slave  (input data, valid, output ready);
endinterface

// File: rtl/st_decoder.sv
// Receive-side udp_msg1 decoder: parses a serialized packet, extracts header
// fields with one-cycle avail strobes and presents the message type on a stream.
module st_decoder
  import st_decoder_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int MAX_BEATS = 4
) (
  input  logic            clk,
  input  logic            rst,
  st_pkt_intf.slave       i_pkt_intf,
  st_intf.master          o_msg_type,
  output fields_t         o_fields,
  output logic            o_err,
  output logic [1:0]      o_err_code
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_BODY, S_DRAIN, S_WAIT} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  fields_t             fields_q, fields_d;
  logic [7:0]          dst_hi_q, dst_hi_d;
  logic                err_q, err_d;
  err_code_e           err_code_q, err_code_d;
  err_code_e           pend_q, pend_d;

  logic                pkt_ready;
  logic                msg_valid;
  msg_type_supported_t msg_data;
  logic                beat_acc;

  assign beat_acc = i_pkt_intf.valid && pkt_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed by the combinational logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      beat_cnt_q <= '0;
      fields_q   <= '0;
      dst_hi_q   <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_TYPE;
      pend_q     <= ERR_TYPE;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      fields_q   <= fields_d;
      dst_hi_q   <= dst_hi_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      pend_q     <= pend_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d                 = state_q;
    beat_cnt_d              = beat_cnt_q;
    fields_d                = fields_q;
    fields_d.seq_num_avail  = 1'b0;
    fields_d.src_port_avail = 1'b0;
    fields_d.dst_port_avail = 1'b0;
    fields_d.length_avail   = 1'b0;
    dst_hi_d                = dst_hi_q;
    err_d                   = 1'b0;
    err_code_d              = err_code_q;
    pend_d                  = pend_q;

    if (beat_acc) begin
      unique case (state_q)
        S_IDLE, S_BODY: begin
          if (i_pkt_intf.sop) begin
            // A sop mid-packet abandons the old packet and restarts at beat 0.
            if (state_q == S_BODY) begin
              err_d      = 1'b1;
              err_code_d = ERR_SHORT;
            end
            if (i_pkt_intf.data[63:56] == MSG_UDP1) begin
              fields_d.msg_type       = MSG_UDP1;
              fields_d.seq_num        = i_pkt_intf.data[55:24];
              fields_d.seq_num_avail  = 1'b1;
              fields_d.src_port       = i_pkt_intf.data[23:8];
              fields_d.src_port_avail = 1'b1;
              dst_hi_d                = i_pkt_intf.data[7:0];
              beat_cnt_d              = CNT_W'(1);
              if (i_pkt_intf.eop) begin
                err_d      = 1'b1;
                err_code_d = ERR_SHORT;
                state_d    = S_IDLE;
              end else begin
                state_d = S_BODY;
              end
            end else if (i_pkt_intf.eop) begin
              err_d      = 1'b1;
              err_code_d = ERR_TYPE;
              state_d    = S_IDLE;
            end else begin
              pend_d  = ERR_TYPE;
              state_d = S_DRAIN;
            end
          end else if (state_q == S_IDLE) begin
            err_d      = 1'b1;
            err_code_d = ERR_NOSOP;
          end else begin
            if (beat_cnt_q == CNT_W'(1)) begin
              fields_d.dst_port       = {dst_hi_q, i_pkt_intf.data[63:56]};
              fields_d.dst_port_avail = 1'b1;
              fields_d.length         = i_pkt_intf.data[55:40];
              fields_d.length_avail   = 1'b1;
            end
            if (i_pkt_intf.eop) begin
              state_d = S_WAIT;
            end else if (beat_cnt_q == LAST_BEAT) begin
              pend_d  = ERR_LONG;
              state_d = S_DRAIN;
            end else begin
              beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (i_pkt_intf.eop) begin
            err_d      = 1'b1;
            err_code_d = pend_q;
            state_d    = S_IDLE;
          end
        end
        default: ;
      endcase
    end

    if (state_q == S_WAIT && o_msg_type.ready) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    pkt_ready = 1'b1;
    msg_valid = 1'b0;
    msg_data  = MSG_NONE;
    if (state_q == S_WAIT) begin
      pkt_ready = 1'b0;
      msg_valid = 1'b1;
      msg_data  = MSG_UDP1;
    end
  end

  assign i_pkt_intf.ready = pkt_ready;
  assign o_msg_type.valid = msg_valid;
  assign o_msg_type.data  = msg_data;
  assign o_fields         = fields_q;
  assign o_err            = err_q;
  assign o_err_code       = err_code_q;

endmodule

// File: tb/tb_st_decoder.sv
// Directed bench for st_decoder: good packets, back-pressure, every error code,
// sop restart mid-packet and reset in the middle of a packet.
module tb_st_decoder;
  import st_decoder_pkg::*;

  logic       clk;
  logic       rst;
  fields_t    fields;
  logic       err;
  logic [1:0] err_code;

  int n_checks = 0;
  int n_errors = 0;

  st_pkt_intf #(.DATA_W(64)) pkt_if ();
  st_intf                    msg_if ();

  st_decoder #(.DATA_W(64), .MAX_BEATS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_pkt_intf (pkt_if),
    .o_msg_type (msg_if),
    .o_fields   (fields),
    .o_err      (err),
    .o_err_code (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] data, input logic sop, input logic eop);
    pkt_if.valid = 1'b1;
    pkt_if.data  = data;
    pkt_if.sop   = sop;
    pkt_if.eop   = eop;
    tick();
    pkt_if.valid = 1'b0;
    pkt_if.sop   = 1'b0;
    pkt_if.eop   = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, 64'(pkt_if.ready), 64'd1);
    check({tag, "_valid"}, 64'(msg_if.valid), 64'd0);
    check({tag, "_mdata"}, 64'(msg_if.data), 64'd0);
    check({tag, "_fields"}, 64'(fields == '0), 64'd1);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_code"}, 64'(err_code), 64'd0);
  endtask

  initial begin
    rst          = 1'b1;
    pkt_if.valid = 1'b0;
    pkt_if.data  = '0;
    pkt_if.sop   = 1'b0;
    pkt_if.eop   = 1'b0;
    msg_if.ready = 1'b0;
    tick();
    tick();
    check_reset_state("reset");
    rst = 1'b0;

    // Good 2-beat packet, consumer not ready yet
    drive(64'h01_DEADBEEF_1234_AB, 1'b1, 1'b0);
    check("g_seq", 64'(fields.seq_num), 64'hDEADBEEF);
    check("g_seq_av", 64'(fields.seq_num_avail), 64'd1);
    check("g_src", 64'(fields.src_port), 64'h1234);
    check("g_src_av", 64'(fields.src_port_avail), 64'd1);
    check("g_dst_av0", 64'(fields.dst_port_avail), 64'd0);
    check("g_valid0", 64'(msg_if.valid), 64'd0);
    drive(64'hCD_0040_0000000000, 1'b0, 1'b1);
    check("g_dst", 64'(fields.dst_port), 64'hABCD);
    check("g_dst_av", 64'(fields.dst_port_avail), 64'd1);
    check("g_len", 64'(fields.length), 64'h0040);
    check("g_len_av", 64'(fields.length_avail), 64'd1);
    check("g_seq_av1", 64'(fields.seq_num_avail), 64'd0);
    check("g_valid", 64'(msg_if.valid), 64'd1);
    check("g_mdata", 64'(msg_if.data), 64'h01);
    check("g_err", 64'(err), 64'd0);

    // Back-pressure for 5 cycles while the next sop waits on the input
    pkt_if.valid = 1'b1;
    pkt_if.data  = 64'h01_11223344_5566_77;
    pkt_if.sop   = 1'b1;
    pkt_if.eop   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_ready", 64'(pkt_if.ready), 64'd0);
      check("bp_valid", 64'(msg_if.valid), 64'd1);
      check("bp_seq", 64'(fields.seq_num), 64'hDEADBEEF);
      check("bp_dst", 64'(fields.dst_port), 64'hABCD);
    end
    msg_if.ready = 1'b1;
    tick();
    check("hs_valid", 64'(msg_if.valid), 64'd0);
    check("hs_ready", 64'(pkt_if.ready), 64'd1);
    check("hs_no_acc", 64'(fields.seq_num_avail), 64'd0);
    tick();
    pkt_if.valid = 1'b0;
    pkt_if.sop   = 1'b0;
    check("b2b_seq_av", 64'(fields.seq_num_avail), 64'd1);
    check("b2b_seq", 64'(fields.seq_num), 64'h11223344);
    drive(64'h88_0100_0000000000, 1'b0, 1'b1);
    check("b2b_dst", 64'(fields.dst_port), 64'h7788);
    check("b2b_len", 64'(fields.length), 64'h0100);
    check("b2b_valid", 64'(msg_if.valid), 64'd1);
    tick();
    check("b2b_done", 64'(msg_if.valid), 64'd0);

    // Unsupported type in a 3-beat packet
    drive(64'h07_00000000_0000_00, 1'b1, 1'b0);
    check("ty_ready0", 64'(pkt_if.ready), 64'd1);
    check("ty_err0", 64'(err), 64'd0);
    drive(64'h0, 1'b0, 1'b0);
    check("ty_ready1", 64'(pkt_if.ready), 64'd1);
    drive(64'h0, 1'b0, 1'b1);
    check("ty_err", 64'(err), 64'd1);
    check("ty_code", 64'(err_code), 64'd0);
    check("ty_valid", 64'(msg_if.valid), 64'd0);
    tick();
    check("ty_err_clr", 64'(err), 64'd0);

    // Short packet: sop and eop on beat 0
    drive(64'h01_00000001_0002_03, 1'b1, 1'b1);
    check("sh_err", 64'(err), 64'd1);
    check("sh_code", 64'(err_code), 64'd1);
    check("sh_dst_av", 64'(fields.dst_port_avail), 64'd0);
    check("sh_len_av", 64'(fields.length_avail), 64'd0);
    check("sh_valid", 64'(msg_if.valid), 64'd0);
    tick();
    check("sh_valid1", 64'(msg_if.valid), 64'd0);
    check("sh_len_av1", 64'(fields.length_avail), 64'd0);

    // Beat without sop while idle
    drive(64'h01_00000000_0000_00, 1'b0, 1'b0);
    check("ns_err", 64'(err), 64'd1);
    check("ns_code", 64'(err_code), 64'd2);

    // Over-long packet: eop only on the 5th beat
    for (int b = 0; b < 4; b++) begin
      drive(64'h01_00000000_0000_00, (b == 0), 1'b0);
      check("lg_err_mid", 64'(err), 64'd0);
    end
    drive(64'h0, 1'b0, 1'b1);
    check("lg_err", 64'(err), 64'd1);
    check("lg_code", 64'(err_code), 64'd3);
    check("lg_valid", 64'(msg_if.valid), 64'd0);

    // sop during BODY restarts as a new beat 0
    drive(64'h01_AAAAAAAA_BBBB_CC, 1'b1, 1'b0);
    drive(64'h01_01020304_0506_07, 1'b1, 1'b0);
    check("rs_err", 64'(err), 64'd1);
    check("rs_code", 64'(err_code), 64'd1);
    check("rs_seq", 64'(fields.seq_num), 64'h01020304);
    check("rs_seq_av", 64'(fields.seq_num_avail), 64'd1);
    drive(64'h08_0009_0000000000, 1'b0, 1'b1);
    check("rs_dst", 64'(fields.dst_port), 64'h0708);
    check("rs_len", 64'(fields.length), 64'h0009);
    check("rs_valid", 64'(msg_if.valid), 64'd1);
    check("rs_err1", 64'(err), 64'd0);
    tick();

    // Reset asserted while in BODY
    drive(64'h01_55555555_6666_77, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    check_reset_state("rb");
    rst = 1'b0;
    drive(64'h01_CAFEF00D_0102_03, 1'b1, 1'b0);
    check("ar_seq", 64'(fields.seq_num), 64'hCAFEF00D);
    check("ar_src", 64'(fields.src_port), 64'h0102);
    drive(64'h04_0010_0000000000, 1'b0, 1'b1);
    check("ar_dst", 64'(fields.dst_port), 64'h0304);
    check("ar_len", 64'(fields.length), 64'h0010);
    check("ar_valid", 64'(msg_if.valid), 64'd1);
    check("ar_err", 64'(err), 64'd0);
    tick();
    check("ar_idle", 64'(msg_if.valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/st_decoder.md
Name: st_decoder

Overview:
- Receive-side counterpart of the streaming encoder.
- Consumes a serialized packet stream, identifies the message type from the header byte, and extracts that message's fields at their template offsets into a fields_t struct with per-field *_avail pulses.
- On a complete, valid packet it presents the decoded type on an st_intf stream.
- Sits between the packet ingress path and the message consumers.

Parameters:
- DATA_W, 64, packet data width in bits; fixed at 64 (8 bytes/beat) for the udp_msg1 template.
- MAX_BEATS, 4, packets longer than this abort with ERR_LONG.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- i_pkt_intf  st_pkt_intf.slave  DATA_W data, valid, ready, sop, eop  serialized packet input.
- o_msg_type  st_intf.master (data type msg_type_supported_t)  decoded message type stream.
- o_fields  output  fields_t  decoded fields plus *_avail strobes.
- o_err  output  1  one-cycle pulse: current packet discarded.
- o_err_code  output  2  valid with o_err: 0 ERR_TYPE, 1 ERR_SHORT, 2 ERR_NOSOP, 3 ERR_LONG.

Behaviour:
- Template udp_msg1, big-endian, byte 0 = first byte of beat 0 (data[63:56]):
  - byte 0: msg_type; 8'h01 = MSG_UDP1, all other values unsupported.
  - bytes 1-4: seq_num[31:0].
  - bytes 5-6: src_port.
  - bytes 7-8: dst_port (spans beats 0/1).
  - bytes 9-10: length.
  - Minimum packet is 2 beats; bytes past 10 are ignored.
- Reset values:
  - i_pkt_intf.ready=1.
  - o_msg_type.valid=0, o_msg_type.data=0.
  - All o_fields data and *_avail = 0.
  - o_err=0, o_err_code=0.
  - FSM=IDLE, beat counter=0.
- Rules apply on the same edge, even mid-packet; any partially captured fields are abandoned.
- A beat is accepted when i_pkt_intf.valid && i_pkt_intf.ready.
- States:
  - IDLE: ready=1.
    - Accepted beat without sop: discard, pulse ERR_NOSOP, stay IDLE.
    - sop beat with supported type: capture msg_type, seq_num, src_port and dst_port high byte; go BODY.
      - If that beat also has eop: ERR_SHORT, stay IDLE.
    - sop beat with unsupported type: go DRAIN with ERR_TYPE pending; if eop on the same beat, pulse ERR_TYPE immediately.
  - BODY: ready=1.
    - Beat 1 captures dst_port low byte and length.
    - eop on beat 1 or later → WAIT.
    - Beats past MAX_BEATS-1 without eop → DRAIN with ERR_LONG pending.
  - DRAIN: ready=1; discard beats until eop, then pulse the pending error and go IDLE.
  - WAIT: ready=0, o_msg_type.valid=1 with data=MSG_UDP1.
    - On o_msg_type.ready go IDLE; ready returns to 1 the following cycle.
- Field timing:
  - seq_num_avail and src_port_avail pulse for 1 cycle, the cycle after beat 0 is accepted.
  - dst_port_avail and length_avail pulse the cycle after beat 1 is accepted.
  - Field values are registered with their avail pulse and held constant until the o_msg_type handshake, or until the next sop in the ERR case.
- Latency: o_msg_type.valid rises exactly 1 cycle after the eop beat is accepted; valid is never withdrawn without ready.
- sop while in BODY: abort the current packet, pulse ERR_SHORT, and treat the beat as a new beat 0 in the same cycle.
- sop while in DRAIN: ignored; keep draining.
- Errors:
  - No o_msg_type is produced for an errored packet.
  - Consumers discard any fields whose avail already pulsed when o_err fires.
  - o_err never pulses for a good packet.
- Back-to-back packets: the earliest new sop acceptance is the cycle after the o_msg_type handshake.
- i_pkt_intf.valid low mid-packet is a protocol violation; the decoder stalls in its current state.

Test Plan:
- Good 2-beat packet:
  - Stimulus: beat0=64'h01_DEADBEEF_1234_AB, beat1=64'hCD_0040_xxxxxxxxxx with eop.
  - Response: seq_num=32'hDEADBEEF and src_port=16'h1234 with avail pulse at T+1; dst_port=16'hABCD and length=16'h0040 with avail pulse at T+2; o_msg_type.valid=1 at T+2.
- Back-pressure: hold o_msg_type.ready=0 for 5 cycles.
  - Response: i_pkt_intf.ready=0 and fields unchanged throughout; after the handshake, the next sop is accepted one cycle later.
- Unsupported type 8'h07 in a 3-beat packet.
  - Response: ready stays 1; o_err=1 with code 0 the cycle after eop; no o_msg_type.valid.
- Short packet: sop+eop on beat 0 with type 8'h01.
  - Response: ERR_SHORT pulse; no dst_port_avail or length_avail; no o_msg_type.
- Beat without sop in IDLE → ERR_NOSOP pulse.
- Packet of 5 beats with no eop until beat 5 → ERR_LONG after eop.
- rst asserted in BODY.
  - Response: next cycle all outputs are at reset values; a following good packet decodes correctly.
